program_loader: RTL and testbench

Upstream boot stage for the multicycle core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 64-bit words. Each word is written into consecutive RAM words starting at address 0. When the load completes it releases the core by holding `cpuRun` high. While `cpuRun` is low, this block owns the RAM write port and the core is held in reset/stall.

---
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot byte-stream loader writing big-endian words into core RAM
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDRESS_SIZE = 11,
    parameter int WORD_SIZE    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              inByte,
    input  logic                    inByteValid,
    output logic                    inByteReady,
    input  logic                    restart,
    output logic [ADDRESS_SIZE-1:0] memAddress,
    output logic [WORD_SIZE-1:0]    memDataIn,
    output logic                    memWrite,
    output logic                    cpuRun,
    output logic                    busy,
    output logic                    loadError
);

    localparam int             BYTES     = WORD_SIZE / 8;
    localparam int             BW        = $clog2(BYTES + 1);
    localparam logic [BW-1:0]  LAST_BYTE = BW'(BYTES - 1);
    localparam logic [16:0]    MAX_WORDS = 17'(1) << ADDRESS_SIZE;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CHECK;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t                  state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [ADDRESS_SIZE:0]   idx_q, idx_d;
    logic [BW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [WORD_SIZE-1:0]    word_q, word_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    data_q, data_d;
    logic [7:0]              xor_q, xor_d;
    logic                    accept;
    logic [16:0]             len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            xor_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            xor_q      <= xor_d;
        end
    end

    // Ready is decoded from the state register only, never from valid.
    assign inByteReady = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                         || (state_q == S_CHECK)
`endif
                         ;
    assign accept     = inByteValid && inByteReady;
    assign memWrite   = (state_q == S_WRITE);
    assign cpuRun     = (state_q == S_DONE);
    assign loadError  = (state_q == S_ERROR);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign memAddress = addr_q;
    assign memDataIn  = data_q;
    assign len        = {1'b0, count_q[15:8], inByte};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        data_d     = data_q;
        xor_d      = xor_q;
        case (state_q)
            S_IDLE: state_d = S_LEN_HI;
            S_LEN_HI: if (accept) begin
                count_d[15:8] = inByte;
                state_d       = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                count_d = len[15:0];
                if (len == 17'd0)           state_d = S_FINAL;
                else if (len > MAX_WORDS)   state_d = S_ERROR;
                else                        state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                word_d = {word_q[WORD_SIZE-9:0], inByte};
                xor_d  = xor_q ^ inByte;
                if (byte_cnt_q == LAST_BYTE) begin
                    byte_cnt_d = '0;
                    addr_d     = idx_q[ADDRESS_SIZE-1:0];
                    data_d     = word_d;
                    state_d    = S_WRITE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 1'b1;
                // Wide compare so N = 2^ADDRESS_SIZE terminates without wrapping.
                if (32'(idx_q) + 32'd1 == 32'(count_q)) state_d = S_FINAL;
                else                                    state_d = S_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: if (accept) begin
                state_d = (inByte == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: if (restart) begin
                state_d    = S_IDLE;
                count_d    = '0;
                idx_d      = '0;
                byte_cnt_d = '0;
                xor_d      = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  inByte;
    logic        inByteValid;
    logic        inByteReady;
    logic        restart;
    logic [10:0] memAddress;
    logic [63:0] memDataIn;
    logic        memWrite;
    logic        cpuRun;
    logic        busy;
    logic        loadError;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [10:0] wr_addr[$];
    logic [63:0] wr_data[$];
    int          last_wr_cyc;
    int          run_cyc;
    int          ready_in_write;
    logic        prev_run = 1'b0;
    logic [7:0]  tb_xor;

    program_loader #(.ADDRESS_SIZE(11), .WORD_SIZE(64)) dut (
        .clk(clk), .reset(reset), .inByte(inByte), .inByteValid(inByteValid),
        .inByteReady(inByteReady), .restart(restart), .memAddress(memAddress),
        .memDataIn(memDataIn), .memWrite(memWrite), .cpuRun(cpuRun), .busy(busy),
        .loadError(loadError)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memWrite) begin
            wr_addr.push_back(memAddress);
            wr_data.push_back(memDataIn);
            last_wr_cyc = cyc;
            if (inByteReady) ready_in_write++;
        end
        if (cpuRun && !prev_run) run_cyc = cyc;
        prev_run = cpuRun;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;
        last_wr_cyc    = -1;
        run_cyc        = -1;
        tb_xor         = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_stall);
        int t;
        t = 0;
        if (max_stall > 0) repeat ($urandom_range(0, max_stall)) @(negedge clk);
        @(negedge clk);
        inByte      = b;
        inByteValid = 1'b1;
        while (!inByteReady && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        inByteValid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int max_stall);
        for (int i = 7; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], max_stall);
            tb_xor = tb_xor ^ w[i*8 +: 8];
        end
    endtask

    task automatic send_count(input logic [15:0] n);
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
    endtask

    task automatic send_cksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(tb_xor, 0);
`endif
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(cpuRun || loadError) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("wait_end_timeout", 64'd1, 64'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inByte = 8'h00; inByteValid = 1'b0; restart = 1'b0;
        last_wr_cyc = -1; run_cyc = -1; ready_in_write = 0; tb_xor = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", inByteReady, 0);
        check("rst_memwrite", memWrite, 0);
        check("rst_addr", memAddress, 0);
        check("rst_data", memDataIn, 0);
        check("rst_cpurun", cpuRun, 0);
        check("rst_busy", busy, 0);
        check("rst_error", loadError, 0);
        reset = 1'b0;

        // Single word load.
        clear_mon();
        send_count(16'd1);
        send_word(64'h0000_0000_000A_3C05, 0);
        send_cksum();
        wait_end();
        check("t1_nwrites", wr_addr.size(), 1);
        check("t1_addr", wr_addr[0], 0);
        check("t1_data", wr_data[0], 64'h0000_0000_000A_3C05);
        check("t1_cpurun", cpuRun, 1);
        check("t1_run_latency", run_cyc, last_wr_cyc + 1);
        check("t1_busy", busy, 0);
        check("t1_hold_data", memDataIn, 64'h0000_0000_000A_3C05);

        // Three words with random upstream stalls.
        do_restart();
        check("restart_cpurun", cpuRun, 0);
        clear_mon();
        send_count(16'd3);
        send_word(64'h1122_3344_5566_7788, 3);
        send_word(64'h99AA_BBCC_DDEE_FF00, 3);
        send_word(64'h0123_4567_89AB_CDEF, 3);
        send_cksum();
        wait_end();
        check("t2_nwrites", wr_addr.size(), 3);
        check("t2_addr0", wr_addr[0], 0);
        check("t2_addr1", wr_addr[1], 1);
        check("t2_addr2", wr_addr[2], 2);
        check("t2_data0", wr_data[0], 64'h1122_3344_5566_7788);
        check("t2_data1", wr_data[1], 64'h99AA_BBCC_DDEE_FF00);
        check("t2_data2", wr_data[2], 64'h0123_4567_89AB_CDEF);
        check("t2_ready_in_write", ready_in_write, 0);
        check("t2_cpurun", cpuRun, 1);

        // Empty load.
        do_restart();
        clear_mon();
        send_count(16'd0);
        send_cksum();
        wait_end();
        check("t3_nwrites", wr_addr.size(), 0);
        check("t3_cpurun", cpuRun, 1);

        // Count too large, then recover.
        do_restart();
        clear_mon();
        send_count(16'h0801);
        wait_end();
        check("t4_error", loadError, 1);
        check("t4_cpurun", cpuRun, 0);
        check("t4_ready", inByteReady, 0);
        check("t4_nwrites", wr_addr.size(), 0);
        do_restart();
        check("t4_error_clear", loadError, 0);
        clear_mon();
        send_count(16'd1);
        send_word(64'hDEAD_BEEF_CAFE_F00D, 0);
        send_cksum();
        wait_end();
        check("t4_reload_addr", wr_addr[0], 0);
        check("t4_reload_data", wr_data[0], 64'hDEAD_BEEF_CAFE_F00D);
        check("t4_reload_run", cpuRun, 1);

        // Reset in the middle of word 0.
        do_restart();
        clear_mon();
        send_count(16'd1);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 0);
        check("t5_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", inByteReady, 0);
        check("t5_rst_data", memDataIn, 0);
        check("t5_rst_addr", memAddress, 0);
        check("t5_rst_memwrite", memWrite, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t5_nwrites", wr_addr.size(), 0);
        clear_mon();
        send_count(16'd1);
        send_word(64'h0F1E_2D3C_4B5A_6978, 0);
        send_cksum();
        wait_end();
        check("t5_nwrites_after", wr_addr.size(), 1);
        check("t5_addr", wr_addr[0], 0);
        check("t5_data", wr_data[0], 64'h0F1E_2D3C_4B5A_6978);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_restart();
        clear_mon();
        send_count(16'd1);
        send_word(64'h0102_0304_0506_0708, 0);
        send_byte(8'h08, 0);
        wait_end();
        check("t6_ck_good_run", cpuRun, 1);
        do_restart();
        clear_mon();
        send_count(16'd1);
        send_word(64'h0102_0304_0506_0708, 0);
        send_byte(8'h09, 0);
        wait_end();
        check("t6_ck_bad_error", loadError, 1);
        check("t6_ck_bad_run", cpuRun, 0);
`endif

        // Full-depth load: 2048 words, no address wrap.
        do_restart();
        clear_mon();
        send_count(16'd2048);
        for (int i = 0; i < 2048; i++) send_word({32'(i), ~32'(i)}, 0);
        send_cksum();
        wait_end();
        check("t7_nwrites", wr_addr.size(), 2048);
        check("t7_first_addr", wr_addr[0], 0);
        check("t7_last_addr", wr_addr[2047], 11'd2047);
        check("t7_last_data", wr_data[2047], {32'd2047, ~32'd2047});
        check("t7_cpurun", cpuRun, 1);
        check("t7_error", loadError, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
